// File: rtl/cv32e40x_rvfi_trace_buffer.sv
// Circular trace buffer for retired RVFI records with start/stop PC triggers and a PC window.
// Define CV32E40X_RVFI_TRACE_TIMESTAMP_EN to prepend a 32-bit cycle stamp to every record.
module cv32e40x_rvfi_trace_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned NMEM  = 1,
    parameter int unsigned CNT_W = 16,
`ifdef CV32E40X_RVFI_TRACE_TIMESTAMP_EN
    localparam int unsigned REC_W = 32 + 69 + 100 * NMEM,
`else
    localparam int unsigned REC_W = 69 + 100 * NMEM,
`endif
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rvfi_valid,
    input  logic [31:0]         rvfi_pc_rdata,
    input  logic [4:0]          rvfi_rd_addr,
    input  logic [31:0]         rvfi_rd_wdata,
    input  logic [32*NMEM-1:0]  rvfi_mem_addr,
    input  logic [4*NMEM-1:0]   rvfi_mem_rmask,
    input  logic [4*NMEM-1:0]   rvfi_mem_wmask,
    input  logic [32*NMEM-1:0]  rvfi_mem_wdata,
    input  logic                cfg_arm_i,
    input  logic                cfg_clear_i,
    input  logic                cfg_overwrite_i,
    input  logic                cfg_start_en_i,
    input  logic [31:0]         cfg_start_pc_i,
    input  logic                cfg_stop_en_i,
    input  logic [31:0]         cfg_stop_pc_i,
    input  logic [31:0]         cfg_win_lo_i,
    input  logic [31:0]         cfg_win_hi_i,
    output logic                trace_valid_o,
    input  logic                trace_ready_i,
    output logic [REC_W-1:0]    trace_data_o,
    output logic [LVL_W-1:0]    level_o,
    output logic [CNT_W-1:0]    dropped_o,
    output logic [1:0]          state_o
);

    localparam int unsigned PW     = $clog2(DEPTH);
    localparam int unsigned BASE_W = 69 + 100 * NMEM;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        CAPTURE = 2'b10,
        FROZEN  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     rdPtr_q, rdPtr_d;
    logic [PW-1:0]     wrPtr_q, wrPtr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  dropped_q, dropped_d;
    logic [REC_W-1:0]  mem_q [DEPTH];

    logic [BASE_W-1:0] recBase;
    logic [REC_W-1:0]  recNew;
    logic              eligible;
    logic              startHit;
    logic              stopHit;
    logic              pushReq;
    logic              popReq;
    logic              full;
    logic              memWe;
    logic              dropInc;

    // Each lane occupies a 100-bit slot; the 28 MSBs above {addr, rmask, wmask, wdata} read as zero.
    always_comb begin
        recBase = '0;
        recBase[BASE_W-1 -: 69] = {rvfi_pc_rdata, rvfi_rd_addr, rvfi_rd_wdata};
        for (int unsigned i = 0; i < NMEM; i++) begin
            recBase[(NMEM-1-i)*100 +: 72] = {rvfi_mem_addr[32*i +: 32], rvfi_mem_rmask[4*i +: 4],
                                             rvfi_mem_wmask[4*i +: 4], rvfi_mem_wdata[32*i +: 32]};
        end
    end

`ifdef CV32E40X_RVFI_TRACE_TIMESTAMP_EN
    logic [31:0] tsCnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tsCnt_q <= '0;
        end else if (cfg_clear_i) begin
            tsCnt_q <= '0;
        end else begin
            tsCnt_q <= tsCnt_q + 32'd1;
        end
    end

    assign recNew = {tsCnt_q, recBase};
`else
    assign recNew = recBase;
`endif

    assign eligible = rvfi_valid && (rvfi_pc_rdata >= cfg_win_lo_i) && (rvfi_pc_rdata <= cfg_win_hi_i);
    assign startHit = (state_q == ARMED) && cfg_start_en_i && rvfi_valid && (rvfi_pc_rdata == cfg_start_pc_i);
    assign stopHit  = (state_q == CAPTURE) && cfg_stop_en_i && rvfi_valid && (rvfi_pc_rdata == cfg_stop_pc_i);
    assign pushReq  = eligible && ((state_q == CAPTURE) || startHit) && !cfg_clear_i;
    assign full     = (level_q == LVL_W'(DEPTH));
    assign popReq   = (level_q != '0) && trace_ready_i && !cfg_clear_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_arm_i) state_d = ARMED;
            ARMED:   if (!cfg_start_en_i || startHit) state_d = CAPTURE;
            CAPTURE: if (stopHit) state_d = FROZEN;
            FROZEN:  state_d = FROZEN;
            default: state_d = IDLE;
        endcase
        if (cfg_clear_i) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        state_o = state_q;
    end

    // A push into a full buffer without a pop either evicts the oldest entry or is discarded.
    always_comb begin
        rdPtr_d   = rdPtr_q;
        wrPtr_d   = wrPtr_q;
        level_d   = level_q;
        dropped_d = dropped_q;
        memWe     = 1'b0;
        dropInc   = 1'b0;
        if (cfg_clear_i) begin
            rdPtr_d   = '0;
            wrPtr_d   = '0;
            level_d   = '0;
            dropped_d = '0;
        end else begin
            if (pushReq) begin
                if (!full || popReq || cfg_overwrite_i) begin
                    memWe   = 1'b1;
                    wrPtr_d = wrPtr_q + PW'(1);
                end
                if (full && !popReq) begin
                    dropInc = 1'b1;
                    if (cfg_overwrite_i) begin
                        rdPtr_d = rdPtr_q + PW'(1);
                    end
                end
            end
            if (popReq) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            if (pushReq && !full && !popReq) begin
                level_d = level_q + LVL_W'(1);
            end else if (!pushReq && popReq) begin
                level_d = level_q - LVL_W'(1);
            end
            if (dropInc && (dropped_q != {CNT_W{1'b1}})) begin
                dropped_d = dropped_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            level_q   <= '0;
            dropped_q <= '0;
        end else begin
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
            level_q   <= level_d;
            dropped_q <= dropped_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (memWe) begin
            mem_q[wrPtr_q] <= recNew;
        end
    end

    assign trace_valid_o = (level_q != '0);
    assign trace_data_o  = trace_valid_o ? mem_q[rdPtr_q] : '0;
    assign level_o       = level_q;
    assign dropped_o     = dropped_q;

endmodule
